// File: rtl/imem_responder.sv
// Instruction memory responder: valid/ready fetch port with fixed LATENCY plus a program-load write port.
// Optional macro IMEM_ALIGN_CHECK_EN turns misaligned fetch addresses into access faults.
module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  // state | meaning
  // IDLE  | ready for a fetch request
  // WAIT  | request accepted, counting down the remaining latency
  // RESP  | response presented, held until resp_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] addr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [31:0] rd_idx;
  logic        rd_fault;
  logic [31:0] rd_word;
  logic [31:0] wr_idx;
  logic        wr_hit;

  // With LATENCY = 1 the read happens on the acceptance edge, before addr_q is loaded.
  always_comb begin
    rd_addr  = (state == ST_IDLE) ? req_addr : addr_q;
    rd_idx   = (rd_addr - BASE_ADDR) >> 2;
    rd_fault = (rd_addr < BASE_ADDR) || (rd_idx >= 32'(DEPTH_WORDS));
`ifdef IMEM_ALIGN_CHECK_EN
    if (rd_addr[1:0] != 2'b00) rd_fault = 1'b1;
`endif
    rd_word  = mem[rd_idx[AW-1:0]];
  end

  always_comb begin
    wr_idx = wr_addr >> 2;
    wr_hit = wr_en && !rst && (wr_idx < 32'(DEPTH_WORDS));
  end

  // Contents survive reset; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_idx[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      addr_q     <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_data  <= rd_fault ? 32'h0 : rd_word;
              resp_err   <= rd_fault;
            end else begin
              state <= ST_WAIT;
              cnt   <= 2'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_data  <= rd_fault ? 32'h0 : rd_word;
            resp_err   <= rd_fault;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table of fetches plus reset, backpressure and same-edge write sequences.
module tb_imem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  imem_responder #(
    .DEPTH_WORDS(256),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          bp;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam logic [31:0] W0   = 32'h0000_0013;
  localparam logic [31:0] W1   = 32'h0050_0093;
  localparam logic [31:0] W2   = 32'h00A0_0113;
  localparam logic [31:0] W3   = 32'h1111_1111;
  localparam logic [31:0] W7   = 32'h7777_0007;
  localparam logic [31:0] W255 = 32'hCAFE_00FF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues one fetch; bp = cycles of resp_ready low once the response is up.
  task automatic do_read(input string name, input logic [31:0] a, input int bp,
                         input logic [31:0] exp_d, input logic exp_e);
    int n;
    int lat;
    logic [31:0] d0;
    logic        e0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({name, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (bp == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFF0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " data"}, resp_data, exp_d);
    check({name, " err"}, 32'(resp_err), 32'(exp_e));
    check({name, " req_ready_busy"}, 32'(req_ready), 32'd0);
    d0 = resp_data;
    e0 = resp_err;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({name, " bp_valid"}, 32'(resp_valid), 32'd1);
      check({name, " bp_data"}, resp_data, d0);
      check({name, " bp_err"}, 32'(resp_err), 32'(e0));
      check({name, " bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, " done_valid"}, 32'(resp_valid), 32'd0);
    check({name, " done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    vecs[0] = '{32'h0000_0000, 0, W0,    1'b0};
    vecs[1] = '{32'h0000_0004, 0, W1,    1'b0};
    vecs[2] = '{32'h0000_03FC, 0, W255,  1'b0};
    vecs[3] = '{32'h0000_0400, 0, 32'h0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, 0, 32'h0, 1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
    vecs[5] = '{32'h0000_0006, 0, 32'h0, 1'b1};
`else
    vecs[5] = '{32'h0000_0006, 0, W1,    1'b0};
`endif
    vecs[6] = '{32'h0000_0008, 5, W2,    1'b0};
    vecs[7] = '{32'h0000_001C, 1, W7,    1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_data", resp_data, 32'h0);
    check("reset resp_err", 32'(resp_err), 32'd0);

    write_word(32'h00, W0);
    write_word(32'h04, W1);
    write_word(32'h08, W2);
    write_word(32'h0C, W3);
    write_word(32'h10, 32'h4444_0004);
    write_word(32'h14, 32'h5555_0005);
    write_word(32'h18, 32'h6666_0006);
    write_word(32'h1C, W7);
    write_word(32'h3FC, W255);
    write_word(32'h400, 32'hBADB_AD00);

    for (int i = 0; i < 8; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].bp, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Reset while a request waits; a write strobed during reset must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_wait in_wait", 32'(resp_valid), 32'd0);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    check("rst_wait resp_valid", 32'(resp_valid), 32'd0);
    check("rst_wait req_ready", 32'(req_ready), 32'd1);
    check("rst_wait resp_data", resp_data, 32'h0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    resp_ready = 1'b0;
    check("rst_wait no_response", 32'(seen), 32'd0);
    do_read("after_rst", 32'h4, 0, W1, 1'b0);

    // Write word 3 on the same edge the read of addr 12 enters RESP.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hC; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("same_edge valid", 32'(resp_valid), 32'd1);
    check("same_edge old_data", resp_data, W3);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("same_edge done", 32'(resp_valid), 32'd0);
    do_read("after_write", 32'hC, 0, 32'hDEAD_BEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
